// File: rtl/debug_dump_sequencer_if.sv
// Debug dump sequencer bus: UART rx/tx strobes,
// debug-word mux and pipeline enables.
interface debug_dump_sequencer_if #(
  parameter int IDX_W = 6
);
  logic             rx_done_tick;
  logic [7:0]       rx_data;
  logic             halt_req;
  logic [31:0]      word_data;
  logic [IDX_W-1:0] word_idx;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_done_tick;
  logic             enable;
  logic             enable_pc;
  logic             busy;

  modport master (
    output rx_done_tick,
    output rx_data,
    output halt_req,
    output word_data,
    output tx_done_tick,
    input  word_idx,
    input  tx_start,
    input  tx_data,
    input  enable,
    input  enable_pc,
    input  busy
  );

  modport slave (
    input  rx_done_tick,
    input  rx_data,
    input  halt_req,
    input  word_data,
    input  tx_done_tick,
    output word_idx,
    output tx_start,
    output tx_data,
    output enable,
    output enable_pc,
    output busy
  );
endinterface

// File: rtl/debug_dump_sequencer.sv
// Debug command/step controller: gates the pipeline,
// then streams a snapshot of debug words MSB first.
module debug_dump_sequencer #(
  parameter int         NUM_WORDS = 40,
  parameter int         IDX_W     = 6,
  parameter logic [7:0] CMD_STEP  = 8'h73,
  parameter logic [7:0] CMD_RUN   = 8'h63,
  parameter logic [7:0] CMD_DUMP  = 8'h64
) (
  input logic                   clk,
  input logic                   reset,
  debug_dump_sequencer_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, STEP, RUN, LOAD, SEND, WAIT
  } state_t;

  state_t      state;
  logic [31:0] shift;
  logic [1:0]  byte_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      shift         <= '0;
      byte_cnt      <= '0;
      bus.word_idx  <= '0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= 8'h00;
      bus.enable    <= 1'b0;
      bus.enable_pc <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.rx_done_tick) begin
            unique case (1'b1)
              bus.rx_data == CMD_STEP: begin
                state         <= STEP;
                bus.enable    <= 1'b1;
                bus.enable_pc <= 1'b1;
                bus.busy      <= 1'b1;
              end
              bus.rx_data == CMD_RUN: begin
                state         <= RUN;
                bus.enable    <= 1'b1;
                bus.enable_pc <= 1'b1;
                bus.busy      <= 1'b1;
              end
              bus.rx_data == CMD_DUMP: begin
                state        <= LOAD;
                bus.word_idx <= '0;
                bus.busy     <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        STEP: begin
          state         <= LOAD;
          bus.word_idx  <= '0;
          bus.enable    <= 1'b0;
          bus.enable_pc <= 1'b0;
        end
        RUN: begin
          if (bus.halt_req) begin
            state         <= LOAD;
            bus.word_idx  <= '0;
            bus.enable    <= 1'b0;
            bus.enable_pc <= 1'b0;
          end
        end
        LOAD: begin
          shift    <= bus.word_data;
          byte_cnt <= '0;
          state    <= SEND;
        end
        SEND: begin
          bus.tx_data  <= shift[31:24];
          bus.tx_start <= 1'b1;
          state        <= WAIT;
        end
        WAIT: begin
          if (bus.tx_done_tick) begin
            if (byte_cnt != 2'd3) begin
              shift    <= {shift[23:0], 8'h00};
              byte_cnt <= byte_cnt + 2'd1;
              state    <= SEND;
            end else if (bus.word_idx != LAST) begin
              bus.word_idx <= bus.word_idx + 1'b1;
              state        <= LOAD;
            end else begin
              bus.word_idx <= '0;
              bus.busy     <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer with a
// responding UART model and a word-mux model.
module tb_debug_dump_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  debug_dump_sequencer_if #(.IDX_W(6)) ifc ();

  debug_dump_sequencer #(
    .NUM_WORDS(40),
    .IDX_W    (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  int ncmp = 0;
  int nerr = 0;
  int pulses = 0;
  int en_cnt = 0;
  int enpc_cnt = 0;
  int max_idx = 0;
  bit inject = 0;
  bit inj_live = 0;
  logic [7:0] bytes[$];

  function automatic logic [31:0] wv(int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 0) return 32'hDEADBEEF;
    return {b, b ^ 8'h5A, ~b, b + 8'h11};
  endfunction

  assign ifc.word_data = wv(int'(ifc.word_idx));

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // UART transmitter model: done two cycles after start
  initial begin
    ifc.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      ifc.tx_done_tick = 1'b0;
      if (inj_live) begin
        ifc.rx_done_tick = 1'b0;
        inj_live = 0;
      end
      if (ifc.tx_start === 1'b1) begin
        bytes.push_back(ifc.tx_data);
        pulses++;
        repeat (2) @(negedge clk);
        ifc.tx_done_tick = 1'b1;
        if (inject && pulses == 10) begin
          ifc.rx_data = 8'h73;
          ifc.rx_done_tick = 1'b1;
          inject = 0;
          inj_live = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ifc.enable === 1'b1) en_cnt++;
      if (ifc.enable_pc === 1'b1) enpc_cnt++;
      if (int'(ifc.word_idx) > max_idx)
        max_idx = int'(ifc.word_idx);
    end
  end

  task automatic clr();
    pulses = 0;
    en_cnt = 0;
    enpc_cnt = 0;
    max_idx = 0;
    bytes.delete();
  endtask

  task automatic send_cmd(logic [7:0] b);
    @(negedge clk);
    ifc.rx_data = b;
    ifc.rx_done_tick = 1'b1;
    @(negedge clk);
    ifc.rx_done_tick = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int n;
    n = 0;
    while (ifc.busy === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n >= 5000), 0);
  endtask

  task automatic check_stream(string tag);
    int bad;
    logic [31:0] w;
    bad = 0;
    check({tag, "_size"}, bytes.size(), 160);
    for (int i = 0; i < bytes.size() && i < 160; i++) begin
      w = wv(i / 4);
      if (bytes[i] !== w[31 - 8*(i%4) -: 8]) bad++;
    end
    check({tag, "_order"}, bad, 0);
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_en"}, ifc.enable, 0);
    check({tag, "_enpc"}, ifc.enable_pc, 0);
    check({tag, "_txs"}, ifc.tx_start, 0);
    check({tag, "_txd"}, ifc.tx_data, 0);
    check({tag, "_idx"}, ifc.word_idx, 0);
    check({tag, "_busy"}, ifc.busy, 0);
  endtask

  initial begin
    int n;
    ifc.rx_done_tick = 1'b0;
    ifc.rx_data = 8'h00;
    ifc.halt_req = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single step then dump
    clr();
    send_cmd(8'h73);
    check("step_busy", ifc.busy, 1);
    wait_idle("step");
    check("step_en", en_cnt, 1);
    check("step_enpc", enpc_cnt, 1);
    check("step_pulses", pulses, 160);
    check_stream("step");
    check("step_idx", ifc.word_idx, 0);

    // dump only
    clr();
    send_cmd(8'h64);
    wait_idle("dump");
    check("dump_en", en_cnt, 0);
    check("dump_b0", bytes[0], 8'hDE);
    check("dump_b1", bytes[1], 8'hAD);
    check("dump_b2", bytes[2], 8'hBE);
    check("dump_b3", bytes[3], 8'hEF);
    check("dump_maxidx", max_idx, 39);
    check("dump_idx0", ifc.word_idx, 0);
    check_stream("dump");

    // run until halt
    clr();
    send_cmd(8'h63);
    repeat (10) @(negedge clk);
    ifc.halt_req = 1'b1;
    wait_idle("run");
    ifc.halt_req = 1'b0;
    check("run_en", 32'(en_cnt >= 10 && en_cnt <= 11), 1);
    check("run_enpc", enpc_cnt, en_cnt);
    check("run_pulses", pulses, 160);
    check_stream("run");

    // step command colliding with tx_done mid-dump
    clr();
    inject = 1;
    send_cmd(8'h64);
    wait_idle("mid");
    repeat (20) @(negedge clk);
    check("mid_inj", inject, 0);
    check("mid_pulses", pulses, 160);
    check("mid_en", en_cnt, 0);
    check("mid_busy", ifc.busy, 0);
    check_stream("mid");

    // reset while waiting on byte 57
    clr();
    send_cmd(8'h64);
    n = 0;
    while (pulses < 57 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("abort_timeout", 32'(n >= 5000), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outs("abort");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_pulses", pulses, 57);
    check("abort_busy", ifc.busy, 0);

    // unknown byte and halt_req in idle
    clr();
    send_cmd(8'h41);
    check("unk_busy", ifc.busy, 0);
    ifc.halt_req = 1'b1;
    repeat (10) @(negedge clk);
    ifc.halt_req = 1'b0;
    check("unk_busy2", ifc.busy, 0);
    check("unk_en", en_cnt, 0);
    check("unk_pulses", pulses, 0);
    check("unk_txd", ifc.tx_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
